// File: rtl/operand_mux_reg.sv
// ============================================================================
// Module      : operand_mux_reg
// Description : Registered N:1 operand selector with valid/ready handshake.
//               One of NUM_IN WIDTH-bit sources is captured per accepted
//               request and held in an output register until the consumer
//               takes it. An out-of-range select picks the last source and
//               raises sel_err alongside the data.
//               Optional build macro OPERAND_MUX_SCAN_EN adds a 'scan' input
//               that steps an internal round-robin pointer instead of using
//               sel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_mux_reg #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 6,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef OPERAND_MUX_SCAN_EN
  input  logic                    scan,
`endif
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [SEL_W-1:0]        cur_sel
);

  // One extra bit so NUM_IN == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0]   C_NUM_IN_EXT = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] C_LAST_IDX   = SEL_W'(NUM_IN - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               sel_err_q, sel_err_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;

  logic               accept;
  logic               drain;
  logic [SEL_W-1:0]   idx;
  logic               idx_err;
  logic [WIDTH-1:0]   mux_data;

`ifdef OPERAND_MUX_SCAN_EN
  logic [SEL_W-1:0]   ptr_q, ptr_d;
`endif

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign sel_err   = sel_err_q;
  assign cur_sel   = cur_sel_q;

  // Handshake: a slot is free when empty or when the held operand leaves now.
  always_comb begin
    req_ready = (state_q == ST_EMPTY) | out_ready;
    accept    = req_valid & req_ready;
    drain     = out_valid & out_ready;
  end

  // Resolve the effective source index; out-of-range selects fall to the last source.
  always_comb begin
    if ({1'b0, sel} < C_NUM_IN_EXT) begin
      idx     = sel;
      idx_err = 1'b0;
    end else begin
      idx     = C_LAST_IDX;
      idx_err = 1'b1;
    end
`ifdef OPERAND_MUX_SCAN_EN
    if (scan) begin
      idx     = ptr_q;
      idx_err = 1'b0;
    end
`endif
  end

  // N:1 source mux on the resolved index (always in range here).
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (idx == SEL_W'(k)) begin
        mux_data = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and load logic for the single output stage.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    sel_err_d = sel_err_q;
    cur_sel_d = cur_sel_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (drain && !accept) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Data is only replaced on accept; after a drain it is left untouched.
    if (accept) begin
      data_d    = mux_data;
      sel_err_d = idx_err;
      cur_sel_d = idx;
    end
  end

`ifdef OPERAND_MUX_SCAN_EN
  // Round-robin pointer advances only on scan accepts and wraps at the last source.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && scan) begin
      if (ptr_q == C_LAST_IDX) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Scan pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Output stage registers; reset drops any held operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      data_q    <= '0;
      sel_err_q <= 1'b0;
      cur_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
      cur_sel_q <= cur_sel_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_mux_reg.sv
// ============================================================================
// Module      : tb_operand_mux_reg
// Description : Scoreboard bench for operand_mux_reg. Directed requests push
//               their expected operand into a queue; a monitor pops and
//               compares each time the DUT hands an operand over.
//               Scan-mode vectors are compiled in with OPERAND_MUX_SCAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_mux_reg;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 6;
  localparam int SEL_W  = 3;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] idx;
    logic             err;
  } exp_t;

  logic                    clk;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    req_valid;
  logic                    req_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [SEL_W-1:0]        cur_sel;
`ifdef OPERAND_MUX_SCAN_EN
  logic                    scan;
`endif

  exp_t sb[$];
  int   total;
  int   bad;

  operand_mux_reg #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef OPERAND_MUX_SCAN_EN
    .scan     (scan),
`endif
    .in_bus   (in_bus),
    .sel      (sel),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err  (sel_err),
    .cur_sel  (cur_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int k, input logic [WIDTH-1:0] v);
    in_bus[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic set_default_srcs();
    for (int k = 0; k < NUM_IN; k++) set_src(k, 16'h1000 + WIDTH'(k));
  endtask

  // Present one request, wait (bounded) for acceptance, record expectation.
  task automatic issue(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] ed,
                       input logic [SEL_W-1:0] ei, input logic ee);
    int   wait_cyc;
    exp_t e;
    sel       = s;
    req_valid = 1'b1;
    #1;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      e.data = ed; e.idx = ei; e.err = ee;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("valid_after_accept", 32'(out_valid), 32'd1);
    end
  endtask

  // Monitor: every handover at the next edge is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("cur_sel",  32'(cur_sel),  32'(e.idx));
        chk("sel_err",  32'(sel_err),  32'(e.err));
      end
    end
  end

  initial begin
    int guard;
    total = 0; bad = 0;
    rst = 1'b1; req_valid = 1'b0; sel = '0; out_ready = 1'b0; in_bus = '0;
`ifdef OPERAND_MUX_SCAN_EN
    scan = 1'b0;
`endif
    set_default_srcs();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-stream: load an operand, then assert reset between edges.
    issue(3'd1, 16'h1001, 3'd1, 1'b0);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data",  32'(out_data),  32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_data",    32'(out_data),  32'h0);
    chk("rst_sel_err", 32'(sel_err),   32'd0);
    chk("rst_cur_sel", 32'(cur_sel),   32'd0);
    chk("rst_ready",   32'(req_ready), 32'd1);

    // Back-to-back stream of all in-range sources.
    out_ready = 1'b1;
    for (int k = 0; k < NUM_IN; k++) issue(SEL_W'(k), 16'h1000 + WIDTH'(k), SEL_W'(k), 1'b0);

    // Out-of-range selects fall to the last source and flag an error.
    set_src(5, 16'hBEEF);
    issue(3'd7, 16'hBEEF, 3'd5, 1'b1);
    issue(3'd6, 16'hBEEF, 3'd5, 1'b1);
    issue(3'd2, 16'h1002, 3'd2, 1'b0);
    set_src(5, 16'h1005);
    @(posedge clk); #1;
    chk("drained_idle", 32'(out_valid), 32'd0);

    // Backpressure: operand must hold while inputs churn.
    out_ready = 1'b0;
    issue(3'd3, 16'h1003, 3'd3, 1'b0);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sel    = SEL_W'(c);
      in_bus = {NUM_IN{16'hA5A5 ^ WIDTH'(c)}};
      @(posedge clk); #1;
      chk("hold_data",    32'(out_data),  32'h1003);
      chk("hold_cur_sel", 32'(cur_sel),   32'd3);
      chk("hold_valid",   32'(out_valid), 32'd1);
    end
    req_valid = 1'b0;
    set_default_srcs();
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Simultaneous drain and accept.
    out_ready = 1'b0;
    issue(3'd1, 16'h1001, 3'd1, 1'b0);
    out_ready = 1'b1;
    issue(3'd4, 16'h1004, 3'd4, 1'b0);
    chk("swap_data", 32'(out_data), 32'h1004);
    @(posedge clk); #1;
    chk("keep_after_drain", 32'(out_data), 32'h1004);

`ifdef OPERAND_MUX_SCAN_EN
    // Scan mode: sel is ignored, pointer walks 0..5 and wraps.
    scan = 1'b1;
    for (int k = 0; k < 8; k++) issue(3'd7, 16'h1000 + WIDTH'(k % NUM_IN), SEL_W'(k % NUM_IN), 1'b0);
    scan = 1'b0;
`endif

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
